// File: rtl/cell_alu_pipelined.sv
// Two-operand ALU cell with word-bank operand select and an accumulator.
// Latency: 2 cycles from accept to out_valid. Throughput: 1 result per cycle.
// Backpressure: out_ready low stalls stage 2; in_ready drops once stage 1 is also full.
module cell_alu_pipelined #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH*(2**SEL_W)-1:0]   in_bus,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_W-1:0]              sel0,
   input  logic [SEL_W-1:0]              sel1,
   input  logic [2:0]                    selOp,
   input  logic                          byPass,
   output logic [WIDTH-1:0]              out,
   output logic                          carry,
   output logic                          zero,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              acc
);

   localparam int NUM_IN = 2**SEL_W;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ACC_ADD, OP_ACC_LOAD, OP_ACC_CLR
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] op0;
      logic [WIDTH-1:0] op1;
      op_e              op;
      logic             byp;
   } s1_t;

   logic [WIDTH-1:0] words [NUM_IN];
   logic             s1_valid;
   s1_t              s1;
   logic             advance;
   logic [WIDTH:0]   sum, diff, acc_sum;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic [WIDTH-1:0] acc_nxt;

   for (genvar k = 0; k < NUM_IN; k++) begin : g_words
      assign words[k] = in_bus[k*WIDTH +: WIDTH];
   end

   assign advance  = !out_valid || out_ready;
   assign in_ready = !reset && (!s1_valid || advance);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.op0 <= words[sel0];
            s1.op1 <= words[sel1];
            s1.op  <= op_e'(selOp);
            s1.byp <= byPass;
         end
      end
   end

   // MSB of diff is the borrow: set exactly when op0 < op1 unsigned.
   assign sum     = {1'b0, s1.op0} + {1'b0, s1.op1};
   assign diff    = {1'b0, s1.op0} - {1'b0, s1.op1};
   assign acc_sum = {1'b0, acc} + {1'b0, s1.op0};

   always_comb begin
      res     = '0;
      res_c   = 1'b0;
      acc_nxt = acc;
      if (s1.byp) begin
         res = s1.op0;
      end else begin
         case (s1.op)
            OP_ADD:      {res_c, res} = sum;
            OP_SUB:      {res_c, res} = diff;
            OP_AND:      res = s1.op0 & s1.op1;
            OP_OR:       res = s1.op0 | s1.op1;
            OP_XOR:      res = s1.op0 ^ s1.op1;
            OP_ACC_ADD: begin
               {res_c, res} = acc_sum;
               acc_nxt      = acc_sum[WIDTH-1:0];
            end
            OP_ACC_LOAD: begin
               res     = s1.op0;
               acc_nxt = s1.op0;
            end
            OP_ACC_CLR:  acc_nxt = '0;
         endcase
      end
   end

   // acc is read and written here so back-to-back accumulator ops need no bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out       <= '0;
         carry     <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out   <= res;
            carry <= res_c;
            acc   <= acc_nxt;
         end
      end
   end

   assign zero = (out == '0);

endmodule

// File: doc/cell_alu_pipelined.md
Name: cell_alu_pipelined

Overview:
Parametrised, pipelined successor to the combinational arithmetic/logic cell. It selects two operands from a parametrised bank of input words and applies one of eight operations, including an internal accumulator. Results pass through a two-stage registered pipeline with valid/ready handshakes on both sides. It sits in the datapath array wherever a cell result must be registered, back-pressured, or accumulated across cycles.

Parameters:
WIDTH, 32, data width of every input word, the result and the accumulator
SEL_W, 3, operand-select width; number of input words NUM_IN = 2**SEL_W (legal SEL_W 1..4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_bus  input  WIDTH*2**SEL_W  packed input words; word k = in_bus[k*WIDTH +: WIDTH]
in_valid  input  1  request presented on in_bus/sel0/sel1/selOp/byPass
in_ready  output  1  cell accepts request this cycle
sel0  input  SEL_W  index of operand0
sel1  input  SEL_W  index of operand1
selOp  input  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 acc_add, 6 acc_load, 7 acc_clear
byPass  input  1  result = operand0, selOp ignored
out  output  WIDTH  registered result
carry  output  1  add: carry-out; sub: borrow (operand0 < operand1 unsigned); otherwise 0
zero  output  1  out == 0
out_valid  output  1  out/carry/zero valid
out_ready  input  1  consumer accepts result
acc  output  WIDTH  current accumulator value (registered)

Behaviour:
- Reset (async, immediate): out, carry, acc, out_valid, and all pipeline valid/data registers = 0. zero = 1, because it is derived from out == 0. in_ready = 0 while reset is high.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready. Operands are muxed from in_bus combinationally at accept. Stage 1 registers operand0, operand1, selOp, byPass, and s1_valid.
- advance = !out_valid || out_ready. in_ready = !reset && (!s1_valid || advance).
- Stage 2: on advance, the stage-1 contents are computed and captured into out/carry/zero. out_valid <= s1_valid.
- Latency: with out_ready held high, a result appears 2 cycles after accept. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, out/carry/zero/out_valid/acc hold. Stage 1 holds. in_ready drops once s1_valid is set.
- Arithmetic: add/sub are WIDTH-bit modular. Carry is taken from a WIDTH+1-bit sum/difference. sub carry = 1 means borrow.
- Accumulator updates only when a stage-1 entry with byPass = 0 is captured into stage 2:
  - acc_add: acc <= acc + operand0; out = new acc; carry = carry-out.
  - acc_load: acc <= operand0; out = operand0.
  - acc_clear: acc <= 0; out = 0.
  - carry = 0 for acc_load and acc_clear.
- Back-to-back accumulator ops are correct without bubbles, because acc is read and written in stage 2.
- byPass = 1: out = operand0, carry = 0, acc unchanged, for any selOp.
- Other ops leave acc unchanged.
- sel0 == sel1 is legal (e.g. sub gives 0, zero = 1, carry = 0).
- Reset mid-operation: all in-flight entries are discarded. acc clears. No output is produced for requests accepted before reset.

Test Plan:
- Reset, then accept add with word0=0xFFFFFFFF, word1=1 (sel0=0, sel1=1), out_ready=1 -> 2 cycles later out_valid=1, out=0, carry=1, zero=1.
- Sub with word2=5, word3=7 -> out=0xFFFFFFFE, carry=1. Then xor word2 with itself -> out=0, zero=1, carry=0.
- acc_load 10, acc_add 3, acc_add 4, acc_clear issued on consecutive cycles -> out sequence 10, 13, 17, 0 on consecutive cycles; acc tracks the same values.
- Hold out_ready=0 for 5 cycles with in_valid=1 continuously -> exactly 2 requests accepted and in_ready=0 after that. out holds its first value. On release, all results are delivered in order with none lost or duplicated.
- byPass=1 with selOp=5, sel0=6, word6=0x1234 -> out=0x1234, acc unchanged.
- Assert reset asynchronously mid-stream between clock edges -> out_valid, out, and acc go to 0 immediately; the first post-reset request gives a correct result with 2-cycle latency.
